// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS result serializer.
// A record is the fail flag plus the six register snapshots of one instruction.
package mips_pkg;

    localparam logic [7:0]  HEADER_BYTE   = 8'hA5;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned NUM_REGS      = 6;

    typedef struct packed {
        logic                      fail;
        logic [NUM_REGS-1:0][15:0] r;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DATA
    } state_e;

    function automatic logic [15:0] header_word(input logic fail);
        return {HEADER_BYTE, 7'b0, fail};
    endfunction

endpackage

// File: rtl/mips_rec_fifo.sv
// Record FIFO with wrapping pointers; pushes while full are ignored here and
// flagged by the caller. A freshly written entry becomes visible one cycle later.
module mips_rec_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t push_rec,
    input  logic pop,
    output logic full,
    output logic empty,
    output rec_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             was_empty_q, was_empty_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Empty also covers the cycle right after the count leaves zero, which
    // gives the reader a settled head entry before it commits to a header.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0) || was_empty_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d    = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        was_empty_d = (count_q == '0);
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            was_empty_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            was_empty_q <= was_empty_d;
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

endmodule

// File: rtl/mips_out_serializer.sv
// Buffers MIPS result records and streams each one as a header word followed
// by six register words (header only for failed instructions).
module mips_out_serializer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_fail,
    input  logic [15:0] in_r0,
    input  logic [15:0] in_r1,
    input  logic [15:0] in_r2,
    input  logic [15:0] in_r3,
    input  logic [15:0] in_r4,
    input  logic [15:0] in_r5,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        overflow
);

    rec_t        in_rec, head;
    logic        full, empty, pop, handshake;
    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic        overflow_q, overflow_d;

    assign in_rec.fail = in_fail;
    assign in_rec.r    = {in_r5, in_r4, in_r3, in_r2, in_r1, in_r0};

    mips_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_rec (in_rec),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    assign handshake = out_valid_q && out_ready;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;
        overflow_d  = overflow_q || (in_valid && full);

        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (!empty) begin
                    out_data_d  = header_word(head.fail);
                    out_valid_d = 1'b1;
                    state_d     = HEAD;
                end
            end
            HEAD: begin
                if (handshake) begin
                    if (head.fail) begin
                        pop         = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        out_data_d = head.r[0];
                        idx_d      = 3'd0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (handshake) begin
                    if (idx_q == 3'd5) begin
                        pop         = 1'b1;
                        out_valid_d = 1'b0;
                        idx_d       = 3'd0;
                        state_d     = IDLE;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        out_data_d = head.r[idx_d];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/mips_out_serializer.md
MIPS_OUT_SERIALIZER -- requirements
Module: mips_out_serializer

Interface
REQ-001 The block SHALL have one clock and reset: clk (rising edge); rst is asynchronous and active-high.
REQ-002 Parameter DEPTH SHALL default to 4 and SHALL set the number of buffered result records.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  result record present; driven by the MIPS stage out_valid.
REQ-006 in_fail  input  1  the record's instruction failed; driven by MIPS instruction_fail.
REQ-007 in_r0..in_r5  input  16 each  register snapshot; driven by MIPS out_0..out_5.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  the consumer accepts the word; a handshake occurs when out_valid and out_ready are both high at a clk edge.
REQ-010 out_data  output  16  serialized word.
REQ-011 overflow  output  1  sticky flag: a record was dropped.

Function
REQ-012 Each clk edge with in_valid=1 SHALL push the record {in_fail, in_r0..in_r5} into a FIFO, but only when occupancy is below DEPTH.
REQ-013 A push while occupancy equals DEPTH SHALL drop the record and set overflow=1. This holds even if a pop happens on the same edge.
REQ-014 overflow SHALL stay 1 until rst.
REQ-015 A push and a pop on the same edge with occupancy below DEPTH SHALL leave occupancy unchanged, and both operations SHALL take effect.
REQ-016 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-017 Each record SHALL be emitted as a header word: 8'hA5, then 7'b0, then fail in bit 0 (header = 16'hA500 | fail).
REQ-018 If fail=0, the header SHALL be followed by exactly six data words in order r0,r1,r2,r3,r4,r5.
REQ-019 If fail=1, only the header SHALL be emitted.
REQ-020 The FSM SHALL have exactly three states: IDLE, HEAD, DATA.
REQ-021 IDLE: if FIFO not empty, then at the next edge load the header into out_data, set out_valid=1, and go to HEAD. Otherwise out_valid=0.
REQ-022 HEAD, on handshake:
- if fail=1, pop and go to IDLE with out_valid=0;
- else load r0, set word index=0, and go to DATA.
REQ-023 DATA, on handshake:
- if index=5, pop and go to IDLE with out_valid=0;
- else increment the index and load r[index+1].
REQ-024 While out_valid=1 and out_ready=0, out_data and the state SHALL hold unchanged.
REQ-025 out_valid and out_data SHALL be registered outputs and SHALL NOT depend combinationally on out_ready.
REQ-026 Latency: a record sampled at edge T into an empty FIFO, with the FSM in IDLE, SHALL give out_valid=1 with its header after edge T+2.
REQ-027 Between records there SHALL be exactly one IDLE cycle with out_valid=0.
REQ-028 The record at the FIFO head SHALL NOT be modified by pushes while it is being serialized.
REQ-029 in_valid SHALL be accepted every cycle, independent of out_ready. There is no back-pressure to the MIPS stage.

Reset
REQ-030 On rst=1 the block SHALL immediately (asynchronously) force:
- out_valid=0, out_data=0, overflow=0;
- FSM=IDLE, word index=0;
- FIFO pointers and occupancy=0.
REQ-031 A rst assertion mid-record SHALL discard all buffered and partially sent records.
REQ-032 On the first edge after rst deasserts, in_valid SHALL be sampled normally.

Structure
REQ-033 A shared package mips_pkg SHALL hold:
- the header constant 8'hA5;
- the DEPTH default;
- the record typedef (fail plus six 16-bit fields);
- the FSM state enum.
REQ-034 The FIFO SHALL be a sub-module mips_rec_fifo with push/pop/full/empty/head ports. It SHALL be instantiated once.
REQ-035 The FSM and output registers SHALL reside in mips_out_serializer.

Verification
REQ-036 Single record, out_ready=1: fail=0, r0..r5=1,2,3,4,5,6 -> stream A500,0001,0002,0003,0004,0005,0006, out_valid high exactly 7 cycles, header after edge T+2.
REQ-037 Failed record: fail=1, r=any -> a single word A501, then out_valid=0.
REQ-038 Back-pressure: out_ready=0 for 5 cycles while data word r2=0x1234 is shown -> out_data holds 0x1234 and out_valid holds 1 throughout, with no skipped or repeated word.
REQ-039 Overflow: out_ready=0, in_valid on 5 consecutive cycles with DEPTH=4 -> overflow=1 after the 5th edge. Releasing out_ready then yields exactly 4 records in order, each separated by one idle cycle.
REQ-040 Wrap: push and drain 10 records with varied values -> order and contents preserved, and overflow stays 0.
REQ-041 Mid-record reset: assert rst during DATA at index 3 -> out_valid=0 and overflow=0 immediately. The next record after deassertion starts with its header.
